// File: rtl/button_bounce_emulator.sv
// Bouncy-button waveform source: a target level accepted over valid/ready becomes an LFSR-timed
// toggle burst, then a stable hold. Define BOUNCE_EMU_STATS_EN to add the glitch_cnt output.
module button_bounce_emulator #(
  parameter int unsigned clock_freq    = 100_000_000,
  parameter int unsigned bounce_time   = 800,
  parameter int unsigned glitch_max    = 50,
  parameter int unsigned settle_time   = 1000,
  parameter logic        initial_value = 1'b0,
  parameter logic [15:0] lfsr_seed     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic        cmd_level,
  output logic        cmd_ready,
  output logic        signal_o,
  output logic        busy,
`ifdef BOUNCE_EMU_STATS_EN
  output logic [15:0] glitch_cnt,
`endif
  output logic        done
);

  localparam int unsigned CycPerUs  = clock_freq / 1_000_000;
  localparam int unsigned BounceCyc = CycPerUs * bounce_time;
  localparam int unsigned GlitchCyc = CycPerUs * glitch_max;
  localparam int unsigned SettleCyc = CycPerUs * settle_time;
  localparam int unsigned GW        = $clog2(GlitchCyc);
  localparam int unsigned GlW       = GW + 1;
  localparam int unsigned WinW      = $clog2(BounceCyc) + 1;
  localparam int unsigned SetW      = $clog2(SettleCyc) + 1;
  localparam logic [15:0] Seed      = (lfsr_seed == 16'h0) ? 16'hACE1 : lfsr_seed;
  localparam logic [15:0] LfsrMask  = 16'hB400;

  if (BounceCyc < 1 || SettleCyc < 1 || GlitchCyc < 2) begin : gen_param_check
    $error("button_bounce_emulator: need BOUNCE_CYC>=1, SETTLE_CYC>=1, GLITCH_CYC>=2");
  end

  typedef enum logic [1:0] {StIdle, StBounce, StSettle} state_e;

  state_e            state_q, state_d;
  logic              sig_q, sig_d;
  logic              target_q, target_d;
  logic              done_q, done_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [GlW-1:0]    gl_q, gl_d;
  logic [SetW-1:0]   set_q, set_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [GlW-1:0]    gl_reload;
  logic              accept;
  logic              toggle;

  assign accept    = cmd_valid && (state_q == StIdle);
  // Run length 1..2^GW drawn from the low LFSR bits.
  assign gl_reload = {1'b0, lfsr_q[GW-1:0]} + GlW'(1);

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    target_d = target_q;
    win_d    = win_q;
    gl_d     = gl_q;
    set_d    = set_q;
    done_d   = 1'b0;
    toggle   = 1'b0;
    lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrMask) : (lfsr_q >> 1);

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_level == sig_q) begin
            done_d = 1'b1;
          end else begin
            sig_d    = cmd_level;
            target_d = cmd_level;
            win_d    = WinW'(BounceCyc - 1);
            gl_d     = gl_reload;
            state_d  = StBounce;
          end
        end
      end
      StBounce: begin
        // Window expiry wins over a same-cycle glitch expiry so the line ends on target.
        if (win_q == '0) begin
          sig_d   = target_q;
          set_d   = SetW'(SettleCyc - 1);
          state_d = StSettle;
        end else begin
          win_d = win_q - WinW'(1);
          if (gl_q == GlW'(1)) begin
            sig_d  = ~sig_q;
            gl_d   = gl_reload;
            toggle = 1'b1;
          end else begin
            gl_d = gl_q - GlW'(1);
          end
        end
      end
      StSettle: begin
        if (set_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          set_d = set_q - SetW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sig_q    <= initial_value;
      target_q <= initial_value;
      done_q   <= 1'b0;
      win_q    <= '0;
      gl_q     <= '0;
      set_q    <= '0;
      lfsr_q   <= Seed;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      target_q <= target_d;
      done_q   <= done_d;
      win_q    <= win_d;
      gl_q     <= gl_d;
      set_q    <= set_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign signal_o  = sig_q;
  assign done      = done_q;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

`ifdef BOUNCE_EMU_STATS_EN
  logic [15:0] glitch_q, glitch_d;

  always_comb begin
    glitch_d = glitch_q;
    if (accept) begin
      glitch_d = '0;
    end else if (toggle && glitch_q != 16'hFFFF) begin
      glitch_d = glitch_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_toggle;
  assign unused_toggle = toggle;
`endif

endmodule

// File: tb/tb_button_bounce_emulator.sv
// Scoreboard bench for button_bounce_emulator: commands push a per-cycle expected waveform built
// from run lengths; a negedge monitor pops and compares. BOUNCE_EMU_STATS_EN also checks glitch_cnt.
`timescale 1ns/1ps
module tb_button_bounce_emulator;

  localparam int BounceCyc = 100;
  localparam int SettleCyc = 50;

  logic clk = 1'b0;
  logic rst_n, cmd_valid, cmd_level;
  logic cmd_ready, signal_o, busy, done;
`ifdef BOUNCE_EMU_STATS_EN
  logic [15:0] glitch_cnt;
`endif

  button_bounce_emulator #(
    .clock_freq   (1_000_000),
    .bounce_time  (100),
    .glitch_max   (8),
    .settle_time  (50),
    .initial_value(1'b0),
    .lfsr_seed    (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_level (cmd_level),
    .cmd_ready (cmd_ready),
    .signal_o  (signal_o),
    .busy      (busy),
`ifdef BOUNCE_EMU_STATS_EN
    .glitch_cnt(glitch_cnt),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sig;
    logic        bsy;
    logic        dn;
    logic        rdy;
    logic [15:0] glitches;
  } exp_t;

  exp_t        exp_q[$];
  logic        idle_level;
  logic [15:0] m_lfsr;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Reference LFSR: the value held during each clock cycle since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic exp_t mk(input logic s, input logic b, input logic d, input logic r,
                              input logic [15:0] g);
    exp_t e;
    e.sig = s; e.bsy = b; e.dn = d; e.rdy = r; e.glitches = g;
    return e;
  endfunction

  // Called in the accept cycle: queue the expectation for every following cycle through done.
  task automatic push_expect(input logic level);
    logic [15:0] l;
    logic        lvl;
    int          run_end;
    int          tog;
    if (level == idle_level) begin
      exp_q.push_back(mk(level, 1'b0, 1'b1, 1'b1, 16'd0));
      return;
    end
    l       = m_lfsr;
    lvl     = level;
    run_end = int'(l[2:0]) + 1;
    tog     = 0;
    for (int k = 1; k <= BounceCyc; k++) begin
      l = lfsr_step(l);
      exp_q.push_back(mk(lvl, 1'b1, 1'b0, 1'b0, 16'd0));
      if (k == run_end && k < BounceCyc) begin
        lvl     = ~lvl;
        tog++;
        run_end = k + int'(l[2:0]) + 1;
      end
    end
    for (int k = 0; k < SettleCyc; k++) exp_q.push_back(mk(level, 1'b1, 1'b0, 1'b0, 16'd0));
    exp_q.push_back(mk(level, 1'b0, 1'b1, 1'b1, 16'(tog)));
    idle_level = level;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("signal_o", signal_o, e.sig);
        check("busy", busy, e.bsy);
        check("done", done, e.dn);
        check("cmd_ready", cmd_ready, e.rdy);
`ifdef BOUNCE_EMU_STATS_EN
        if (e.dn) check("glitch_cnt", glitch_cnt, e.glitches);
`endif
      end else begin
        check("idle_signal_o", signal_o, idle_level);
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
        check("idle_cmd_ready", cmd_ready, 1'b1);
      end
    end
  end

  // Asserts reset at once, checks outputs without a clock edge, releases, returns at drive point.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    idle_level = 1'b0;
    check("rst_signal_o", signal_o, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  // Holds the command until the model says the DUT is idle; returns at the next drive point.
  task automatic issue(input logic level);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_level = level;
    while (exp_q.size() != 0 && waited < 400) begin
      @(negedge clk); #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got busy after %0d cycles expected idle", waited);
      cmd_valid = 1'b0;
      return;
    end
    push_expect(level);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 400) begin
      @(negedge clk); #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending cycles expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst_n      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_level  = 1'b0;
    idle_level = 1'b0;
    #1;
    reset_pulse();

    // Same-level command: done only, no edge.
    issue(1'b0);
    wait_idle();

    // Full burst toward 1, then a held 0 command presented while busy.
    reset_pulse();
    idle_cycles(3);
    issue(1'b1);
    idle_cycles(19);
    issue(1'b0);
    wait_idle();

    // Reset mid-burst aborts; the same start offset replays the same burst.
    reset_pulse();
    idle_cycles(3);
    issue(1'b1);
    idle_cycles(39);
    reset_pulse();
    idle_cycles(3);
    issue(1'b1);
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      idle_cycles(int'($urandom_range(0, 30)));
      issue(1'($urandom_range(0, 1)));
    end
    wait_idle();
    idle_cycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
